// File: rtl/water_heater_controller.sv
// water_heater_controller
// Purpose : latches the wash target on an accepted start, drives the heater relay
//           from water-sensor samples until the target is confirmed, then holds
//           the temperature with hysteresis. Flags timeout and overshoot faults.
// Latency : every output is registered, so outputs change on the edge after the input.
// Backpressure: none. Samples are consumed whenever water_temp_valid is high.
// Ports:
//   clk                  in   1  system clock, rising edge
//   reset                in   1  asynchronous, active-low reset
//   start                in   1  one-cycle start request, honoured only in IDLE
//   abort                in   1  return to IDLE from any state
//   selected_temperature in   6  target in degC, sampled on an accepted start
//   water_temp           in   6  sensor reading in degC
//   water_temp_valid     in   1  water_temp is valid this cycle
//   heater_on            out  1  heater relay drive
//   temp_reached         out  1  high in HOLD
//   busy                 out  1  high in any state other than IDLE
//   fault                out  1  high in FAULT
//   target_temperature   out  6  latched target
module water_heater_controller #(
  parameter int HYSTERESIS     = 2,
  parameter int SETTLE_SAMPLES = 3,
  parameter int TIMEOUT_CYCLES = 600,
  parameter int OVERSHOOT      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] selected_temperature,
  input  logic [5:0] water_temp,
  input  logic       water_temp_valid,
  output logic       heater_on,
  output logic       temp_reached,
  output logic       busy,
  output logic       fault,
  output logic [5:0] target_temperature
);

  localparam int TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_SAMPLES + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEATING = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SETTLE_SAMPLES);
  localparam logic [6:0]          OVERSHOOT_7 = 7'(OVERSHOOT);
  localparam logic [6:0]          HYST_7      = 7'(HYSTERESIS);

  // Registered state
  logic [1:0]          r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [SETTLE_W-1:0] r_settle;
  logic [5:0]          r_target;
  logic                r_heater;
  logic                r_reached;
  logic                r_busy;
  logic                r_fault;

  // Sample qualification
  logic [6:0]          w_sample_ext;
  logic [6:0]          w_target_ext;
  logic [6:0]          w_hyst_thr;
  logic                w_overshoot;
  logic                w_at_target;
  logic                w_below_thr;
  logic                w_timeout;
  logic [SETTLE_W-1:0] w_settle_inc;
  logic [SETTLE_W-1:0] w_settle_upd;
  logic                w_settled;

  // Next-state values
  logic [1:0]          w_nxt_state;
  logic [TIMER_W-1:0]  w_nxt_timer;
  logic [SETTLE_W-1:0] w_nxt_settle;
  logic [5:0]          w_nxt_target;
  logic                w_nxt_heater;

  // Comparisons are widened to 7 bits so target + OVERSHOOT cannot wrap near 63.
  assign w_sample_ext = {1'b0, water_temp};
  assign w_target_ext = {1'b0, r_target};
  assign w_overshoot  = water_temp_valid && (w_sample_ext > (w_target_ext + OVERSHOOT_7));
  assign w_at_target  = (water_temp >= r_target);

  // Re-enable threshold clamps at 0; with a threshold of 0 no sample is below
  // it, which keeps the heater off for cold or very low targets.
  assign w_hyst_thr   = (w_target_ext > HYST_7) ? (w_target_ext - HYST_7) : 7'd0;
  assign w_below_thr  = (w_sample_ext < w_hyst_thr);

  assign w_timeout    = (r_timer == TIMER_LAST);

  // Saturating settle counter; invalid cycles leave it untouched.
  assign w_settle_inc = (r_settle == SETTLE_DONE) ? r_settle : (r_settle + 1'b1);

  always_comb begin
    w_settle_upd = r_settle;
    if (water_temp_valid) begin
      w_settle_upd = w_at_target ? w_settle_inc : '0;
    end
  end

  assign w_settled = water_temp_valid && w_at_target && (w_settle_upd == SETTLE_DONE);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_timer  = r_timer;
    w_nxt_settle = r_settle;
    w_nxt_target = r_target;
    w_nxt_heater = r_heater;

    if (abort) begin
      // Abort wins over everything, including a simultaneous start in IDLE.
      w_nxt_state  = ST_IDLE;
      w_nxt_timer  = '0;
      w_nxt_settle = '0;
      w_nxt_heater = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nxt_heater = 1'b0;
          if (start) begin
            w_nxt_target = selected_temperature;
            w_nxt_timer  = '0;
            w_nxt_settle = '0;
            if (selected_temperature == 6'd0) begin
              // Cold wash: nothing to heat, go straight to holding.
              w_nxt_state  = ST_HOLD;
              w_nxt_heater = 1'b0;
            end else begin
              w_nxt_state  = ST_HEATING;
              w_nxt_heater = 1'b1;
            end
          end
        end

        ST_HEATING: begin
          if (w_overshoot || w_timeout) begin
            w_nxt_state  = ST_FAULT;
            w_nxt_timer  = '0;
            w_nxt_settle = '0;
            w_nxt_heater = 1'b0;
          end else if (w_settled) begin
            w_nxt_state  = ST_HOLD;
            w_nxt_timer  = '0;
            w_nxt_settle = '0;
            w_nxt_heater = 1'b0;
          end else begin
            w_nxt_timer  = r_timer + 1'b1;
            w_nxt_settle = w_settle_upd;
            w_nxt_heater = 1'b1;
          end
        end

        ST_HOLD: begin
          if (w_overshoot) begin
            w_nxt_state  = ST_FAULT;
            w_nxt_heater = 1'b0;
          end else if (water_temp_valid && w_below_thr) begin
            w_nxt_heater = 1'b1;
          end else if (water_temp_valid && w_at_target) begin
            w_nxt_heater = 1'b0;
          end
        end

        ST_FAULT: begin
          w_nxt_heater = 1'b0;
        end

        default: begin
          w_nxt_state  = ST_IDLE;
          w_nxt_timer  = '0;
          w_nxt_settle = '0;
          w_nxt_heater = 1'b0;
        end
      endcase
    end
  end

  // Flags are decoded from the next state so they change on the same edge as it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_settle  <= '0;
      r_target  <= '0;
      r_heater  <= 1'b0;
      r_reached <= 1'b0;
      r_busy    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_timer   <= w_nxt_timer;
      r_settle  <= w_nxt_settle;
      r_target  <= w_nxt_target;
      r_heater  <= w_nxt_heater;
      r_reached <= (w_nxt_state == ST_HOLD);
      r_busy    <= (w_nxt_state != ST_IDLE);
      r_fault   <= (w_nxt_state == ST_FAULT);
    end
  end

  assign heater_on          = r_heater;
  assign temp_reached       = r_reached;
  assign busy               = r_busy;
  assign fault              = r_fault;
  assign target_temperature = r_target;

endmodule

// File: tb/tb_water_heater_controller.sv
// tb_water_heater_controller
// Purpose : directed plus random stimulus against a behavioural reference model.
// Ports   : none (top-level bench).
module tb_water_heater_controller;

  localparam int HYST   = 2;
  localparam int SETTLE = 3;
  localparam int TMO    = 600;
  localparam int OVS    = 8;

  localparam int PH_IDLE = 0;
  localparam int PH_HEAT = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_FLT  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [5:0] selected_temperature;
  logic [5:0] water_temp;
  logic       water_temp_valid;
  logic       heater_on;
  logic       temp_reached;
  logic       busy;
  logic       fault;
  logic [5:0] target_temperature;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase, target, edges spent heating, consecutive hits, relay
  int m_phase;
  int m_target;
  int m_heat_edges;
  int m_hits;
  bit m_heater;

  water_heater_controller #(
    .HYSTERESIS(HYST), .SETTLE_SAMPLES(SETTLE), .TIMEOUT_CYCLES(TMO), .OVERSHOOT(OVS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .selected_temperature(selected_temperature), .water_temp(water_temp),
    .water_temp_valid(water_temp_valid), .heater_on(heater_on),
    .temp_reached(temp_reached), .busy(busy), .fault(fault),
    .target_temperature(target_temperature)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase      = PH_IDLE;
    m_target     = 0;
    m_heat_edges = 0;
    m_hits       = 0;
    m_heater     = 1'b0;
  endtask

  // One clock edge of the specified behaviour, applied with plain arithmetic.
  task automatic model_edge(input bit st, input bit ab, input int sel, input int t, input bit v);
    int thr;
    bit over;
    over = v && (t > m_target + OVS);
    thr  = (m_target - HYST < 0) ? 0 : m_target - HYST;
    if (ab) begin
      m_phase = PH_IDLE; m_heater = 0; m_heat_edges = 0; m_hits = 0;
    end else if (m_phase == PH_IDLE) begin
      if (st) begin
        m_target = sel; m_heat_edges = 0; m_hits = 0;
        if (sel == 0) begin m_phase = PH_HOLD; m_heater = 0; end
        else begin m_phase = PH_HEAT; m_heater = 1; end
      end
    end else if (m_phase == PH_HEAT) begin
      m_heat_edges++;
      if (v) m_hits = (t >= m_target) ? m_hits + 1 : 0;
      if (over || m_heat_edges == TMO) begin
        m_phase = PH_FLT; m_heater = 0;
      end else if (m_hits >= SETTLE) begin
        m_phase = PH_HOLD; m_heater = 0;
      end
    end else if (m_phase == PH_HOLD) begin
      if (over) begin m_phase = PH_FLT; m_heater = 0; end
      else if (v && t < thr) m_heater = 1;
      else if (v && t >= m_target) m_heater = 0;
    end else begin
      m_heater = 0;
    end
  endtask

  task automatic check_all();
    check("heater_on",    heater_on,          (m_phase == PH_HEAT) ? 1 : (m_phase == PH_HOLD) ? m_heater : 0);
    check("temp_reached", temp_reached,       m_phase == PH_HOLD);
    check("busy",         busy,               m_phase != PH_IDLE);
    check("fault",        fault,              m_phase == PH_FLT);
    check("target",       target_temperature, m_target);
  endtask

  task automatic step(input bit st, input bit ab, input int sel, input int t, input bit v);
    start = st; abort = ab;
    selected_temperature = 6'(sel); water_temp = 6'(t); water_temp_valid = v;
    @(posedge clk);
    model_edge(st, ab, sel, t, v);
    #1;
    check_all();
  endtask

  initial begin
    int r;
    bit st, ab, v;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    selected_temperature = '0; water_temp = '0; water_temp_valid = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Normal heat; selected_temperature changes after latching are ignored
    step(1, 0, 40, 0, 0);
    check("heat_on_after_start", heater_on, 1);
    step(0, 0, 7, 30, 1);
    step(0, 0, 7, 40, 1);
    step(0, 0, 7, 41, 1);
    check("not_reached_before_42", temp_reached, 0);
    step(0, 0, 7, 42, 1);
    check("reached_after_42", temp_reached, 1);
    check("heater_off_after_42", heater_on, 0);
    check("target_40", target_temperature, 40);
    step(0, 1, 0, 0, 0);
    check("abort_busy", busy, 0);
    check("abort_target_holds", target_temperature, 40);

    // Settle interruption with an invalid gap
    step(1, 0, 40, 0, 0);
    step(0, 0, 40, 40, 1);
    step(0, 0, 40, 10, 0);
    step(0, 0, 40, 40, 1);
    step(0, 0, 40, 39, 1);
    step(0, 0, 40, 40, 1);
    step(0, 0, 40, 40, 1);
    check("settle_not_yet", temp_reached, 0);
    step(0, 0, 40, 40, 1);
    check("settle_reached", temp_reached, 1);

    // Hysteresis in HOLD
    step(0, 0, 40, 39, 1); check("hyst_39_off", heater_on, 0);
    step(0, 0, 40, 37, 1); check("hyst_37_on", heater_on, 1);
    step(0, 0, 40, 39, 1); check("hyst_39_stays", heater_on, 1);
    step(0, 0, 40, 40, 1); check("hyst_40_off", heater_on, 0);
    step(1, 0, 10, 40, 1); check("start_in_hold_ignored", target_temperature, 40);
    step(1, 1, 10, 0, 0);  check("abort_and_start", busy, 0);

    // Cold wash
    step(1, 0, 0, 0, 0);
    check("cold_reached", temp_reached, 1);
    repeat (4) begin
      step(0, 0, 0, 0, 1);
      check("cold_heater_off", heater_on, 0);
    end
    step(0, 1, 0, 0, 0);

    // Timeout: FAULT exactly TMO edges after HEATING entry
    step(1, 0, 60, 20, 1);
    repeat (TMO - 1) step(0, 0, 60, 20, 1);
    check("no_fault_at_599", fault, 0);
    step(0, 0, 60, 20, 1);
    check("fault_at_600", fault, 1);
    check("fault_heater_off", heater_on, 0);
    step(1, 0, 20, 20, 1);
    check("start_in_fault_ignored", fault, 1);
    step(0, 1, 0, 0, 0);
    check("abort_clears_fault", fault, 0);

    // Overshoot boundary
    step(1, 0, 30, 0, 0);
    step(0, 0, 30, 38, 1); check("overshoot_38_ok", fault, 0);
    step(0, 0, 30, 39, 1); check("overshoot_39_fault", fault, 1);
    step(0, 1, 0, 0, 0);

    // Target 63 must not wrap
    step(1, 0, 63, 0, 0);
    repeat (3) step(0, 0, 63, 63, 1);
    check("t63_reached", temp_reached, 1);
    check("t63_no_fault", fault, 0);
    step(0, 1, 0, 0, 0);

    // Reset mid-HEATING, asserted between edges
    step(1, 0, 50, 0, 0);
    step(0, 0, 50, 10, 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_heater", heater_on, 0);
    check("rst_busy", busy, 0);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 20, 0, 0);
    check("restart_heater", heater_on, 1);
    check("restart_target", target_temperature, 20);

    // Random traffic around the current target
    repeat (1500) begin
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) r = $urandom_range(0, 63);
      else r = m_target + $urandom_range(0, 16) - 6;
      if (r < 0) r = 0;
      if (r > 63) r = 63;
      step(st, ab, $urandom_range(0, 63), r, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/water_heater_controller.md
# water_heater_controller

Consumer of the wash-temperature selection: on a start pulse it latches `selected_temperature` as the wash target and drives the heater from water-sensor samples. It heats until the target is confirmed, then holds it with hysteresis. It flags timeout and overshoot faults. It sits between the temperature selector and the heater relay / temperature sensor in the washing-machine datapath.

## Interface
Parameters:
- HYSTERESIS, 2: in HOLD, the heater re-enables when water drops below target − HYSTERESIS (°C).
- SETTLE_SAMPLES, 3: number of consecutive valid samples ≥ target needed to declare the target reached.
- TIMEOUT_CYCLES, 600: maximum clk cycles allowed in HEATING (60 s at a 100 ms clock).
- OVERSHOOT, 8: a valid sample > target + OVERSHOOT is a fault.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin heating; only honoured in IDLE.
- abort  in  1  return to IDLE from any state.
- selected_temperature  in  6  target in °C from the temperature selector; sampled only on an accepted start.
- water_temp  in  6  sensor reading in °C.
- water_temp_valid  in  1  water_temp is valid this cycle.
- heater_on  out  1  heater relay drive.
- temp_reached  out  1  high in HOLD.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  high in FAULT.
- target_temperature  out  6  latched target.

## Operation
- States: IDLE, HEATING, HOLD, FAULT.
- IDLE:
  - All flags are low.
  - On start, latch the target. If the target is 0 (cold wash), go directly to HOLD. Otherwise go to HEATING.
- HEATING:
  - heater_on = 1.
  - The timer counts from 0 every cycle.
  - Each valid sample ≥ target increments settle_cnt. Each valid sample < target clears it.
  - A cycle with valid = 0 leaves settle_cnt unchanged.
  - When settle_cnt would reach SETTLE_SAMPLES, go to HOLD.
  - When the timer reaches TIMEOUT_CYCLES−1, go to FAULT.
- HOLD:
  - temp_reached = 1.
  - heater_on is set by a valid sample < max(target − HYSTERESIS, 0) and cleared by a valid sample ≥ target. Otherwise it holds its value.
  - On entry, heater_on = 0.
  - With target = 0, the heater never turns on.
  - Remains in HOLD until abort.
- FAULT:
  - fault = 1 and heater_on = 0.
  - Exits only via abort or reset.
- Overshoot: in HEATING or HOLD, a valid sample > target + OVERSHOOT goes to FAULT.
  - The comparison is done in 7 bits, so a target near 63 cannot wrap.
- start outside IDLE is ignored. selected_temperature changes after latching are ignored.
- Arithmetic:
  - The timer width is clog2(TIMEOUT_CYCLES+1).
  - settle_cnt is clog2(SETTLE_SAMPLES+1) bits and saturates.
  - The hysteresis subtraction saturates at 0.

## Timing
- Reset values: every output is 0, target_temperature = 0, state = IDLE, and the timer and settle_cnt are cleared.
- All outputs are registered and change on the same clk edge as the state change.
- start is sampled at edge N. busy, heater_on and target_temperature are valid after edge N, so latency is 1 cycle.
- The SETTLE_SAMPLES-th qualifying sample is sampled at edge M. After edge M: temp_reached = 1 and heater_on = 0.
- Timeout: FAULT is entered exactly TIMEOUT_CYCLES edges after entering HEATING.
- Priority at the same edge:
  - abort > overshoot fault > timeout > reached.
  - abort and start together in IDLE: stay in IDLE.
- abort takes effect at the next edge. All outputs drop to their reset values, except target_temperature, which holds.
- Reset asserted mid-operation forces the reset values immediately, independent of clk.

## Test plan
- Normal heat: reset, selected_temperature=40, start. Then samples 30, 40, 41, 42 with valid every cycle. Expect:
  - heater_on=1 one cycle after start.
  - temp_reached=1 and heater_on=0 after the 42 sample.
  - target_temperature=40 throughout.
- Settle interruption: target 40, samples 40, 40, 39, 40, 40, 40. Expect HOLD only after the final 40. A gap with valid=0 between the first two samples must not break the count.
- Hysteresis in HOLD (target 40): sample 39 → heater stays 0; sample 37 → heater_on=1; sample 39 → stays 1; sample 40 → heater_on=0.
- Cold wash and timeout:
  - Cold wash: selected_temperature=0, start → temp_reached=1 next cycle, heater_on never 1.
  - Timeout: target 60 with samples fixed at 20 → fault=1 and heater_on=0 exactly 600 cycles after HEATING entry.
- Overshoot and abort:
  - Target 30, sample 39 in HEATING → FAULT.
  - A start in FAULT is ignored.
  - abort → IDLE with all flags 0.
  - Target 63 with sample 63 → no fault.
- Reset mid-HEATING: drive reset=0 between clk edges → heater_on and busy go to 0 immediately. After release, IDLE accepts a new start with selected_temperature=20.
